// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: active-low glyphs
// (gfedcba order) and the scan state encoding.
package display_scan_ctrl_pkg;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_DEAD  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment pattern, with a blank
// override that wins over the nibble.
module hex7seg_dec
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared decoder drives the
// digits in turn, with a one-cycle dead slot between digits to avoid ghosting.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [31:0]           valor,
    output logic                  pendente,
    output logic [6:0]            saida,
    output logic [NUM_DIGITS-1:0] anodo,
    output logic [2:0]            digito
);

    localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [31:0]     VALUE_MASK = 32'hFFFF_FFFF >> (32 - 4 * NUM_DIGITS);

    logic [PW-1:0]         presc_q, presc_d;
    scan_state_t           state_q, state_d;
    logic [2:0]            digito_q, digito_d;
    logic [31:0]           active_q, active_d;
    logic [31:0]           pend_val_q, pend_val_d;
    logic                  pendente_q, pendente_d;
    logic [6:0]            saida_q, saida_d;
    logic [NUM_DIGITS-1:0] anodo_q, anodo_d;

    logic       tick;
    logic       frame_wrap;
    logic       lz_blank;
    logic [3:0] dec_nibble;
    logic       dec_blank;

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        frame_wrap = (state_q == ST_DEAD) && (digito_q == DIGIT_LAST);

        state_d  = state_q;
        digito_d = digito_q;
        case (state_q)
            ST_DRIVE: begin
                if (tick) state_d = ST_DEAD;
            end
            ST_DEAD: begin
                state_d  = ST_DRIVE;
                digito_d = (digito_q == DIGIT_LAST) ? 3'd0 : digito_q + 3'd1;
            end
        endcase
    end

    // A load landing on the frame wrap goes straight to the active value.
    always_comb begin
        pend_val_d = load ? (valor & VALUE_MASK) : pend_val_q;
        pendente_d = pendente_q;
        active_d   = active_q;
        if (frame_wrap) begin
            pendente_d = 1'b0;
            if (load)            active_d = valor & VALUE_MASK;
            else if (pendente_q) active_d = pend_val_q;
        end else if (load) begin
            pendente_d = 1'b1;
        end
    end

    // Outputs are decoded from next-state values so they register in step with the scan.
    always_comb begin
        lz_blank   = BLANK_LZ && (digito_d != 3'd0) &&
                     ((active_d >> {digito_d, 2'b00}) == 32'd0);
        dec_nibble = active_d[{digito_d, 2'b00} +: 4];
        dec_blank  = (state_d == ST_DEAD) || lz_blank;
        anodo_d    = (state_d == ST_DRIVE) ? ~(NUM_DIGITS'(1) << digito_d) : '1;
    end

    hex7seg_dec u_dec (
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .seg    (saida_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            state_q    <= ST_DRIVE;
            digito_q   <= 3'd0;
            active_q   <= 32'd0;
            pend_val_q <= 32'd0;
            pendente_q <= 1'b0;
            saida_q    <= SEG_BLANK;
            anodo_q    <= '1;
        end else begin
            presc_q    <= presc_d;
            state_q    <= state_d;
            digito_q   <= digito_d;
            active_q   <= active_d;
            pend_val_q <= pend_val_d;
            pendente_q <= pendente_d;
            saida_q    <= saida_d;
            anodo_q    <= anodo_d;
        end
    end

    assign pendente = pendente_q;
    assign saida    = saida_q;
    assign anodo    = anodo_q;
    assign digito   = digito_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (leading-zero blanking off/on)
// share stimulus and are checked every cycle against a cycle-count model.
module tb_display_scan_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FRAME = ND * SD;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [31:0]   valor = 32'd0;

    logic          pend0, pend1;
    logic [6:0]    seg0, seg1;
    logic [ND-1:0] an0, an1;
    logic [2:0]    dig0, dig1;

    display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .load(load), .valor(valor),
        .pendente(pend0), .saida(seg0), .anodo(an0), .digito(dig0)
    );

    display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut1 (
        .clock(clock), .reset_n(reset_n), .load(load), .valor(valor),
        .pendente(pend1), .saida(seg1), .anodo(an1), .digito(dig1)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: clock edges since reset release, plus active/pending values.
    int          c_m    = 0;
    logic [31:0] act_m  = 32'd0;
    logic [31:0] pval_m = 32'd0;
    logic        pend_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_lit();
        return reset_n && (c_m != 0) && (c_m % SD != 0);
    endfunction

    function automatic int cur_digit();
        if (!reset_n || c_m == 0) return 0;
        return ((c_m - 1) / SD) % ND;
    endfunction

    function automatic logic [6:0] exp_seg(input bit lz);
        int d;
        bit any;
        if (!is_lit()) return 7'b1111111;
        d = cur_digit();
        any = 1'b0;
        for (int k = d; k < ND; k++)
            if (act_m[4*k +: 4] != 4'h0) any = 1'b1;
        if (lz && d > 0 && !any) return 7'b1111111;
        return GLYPH[act_m[4*d +: 4]];
    endfunction

    function automatic logic [ND-1:0] exp_an();
        logic [ND-1:0] a;
        a = '1;
        if (is_lit()) a[cur_digit()] = 1'b0;
        return a;
    endfunction

    always @(negedge clock) begin
        check("seg_nolz", seg0, exp_seg(1'b0));
        check("seg_lz",   seg1, exp_seg(1'b1));
        check("anodo0",   an0, exp_an());
        check("anodo1",   an1, exp_an());
        check("digito0",  dig0, cur_digit());
        check("digito1",  dig1, cur_digit());
        check("pend0",    pend0, pend_m);
        check("pend1",    pend1, pend_m);
        check("anodo_single_low", ($countones(~an1) <= 1), 1);
    end

    task automatic model_reset();
        c_m = 0; act_m = 32'd0; pval_m = 32'd0; pend_m = 1'b0;
    endtask

    // Drive inputs, take one clock edge, update the model, settle at edge+2.
    task automatic cyc(input logic ld, input logic [31:0] v);
        load = ld;
        valor = v;
        @(posedge clock);
        if (reset_n) begin
            if (c_m > 0 && c_m % FRAME == 0) begin
                if (load)        act_m = valor & 32'h0000_FFFF;
                else if (pend_m) act_m = pval_m;
                pend_m = 1'b0;
            end else if (load) begin
                pval_m = valor & 32'h0000_FFFF;
                pend_m = 1'b1;
            end
            c_m++;
        end
        #2;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 32'd0);
    endtask

    task automatic run_to(input int rem);
        int n;
        n = 0;
        while ((c_m % FRAME) != rem && n < 200) begin
            cyc(1'b0, 32'd0);
            n++;
        end
        if (n >= 200) check("run_to_timeout", n, 0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;

        // 1. reset held, then release
        repeat (3) @(posedge clock);
        #2;
        check("t1_rst_seg", seg1, 7'b1111111);
        check("t1_rst_an",  an1, 4'b1111);
        check("t1_rst_dig", dig1, 0);
        check("t1_rst_pend", pend1, 0);
        reset_n = 1'b1;
        cyc(1'b0, 32'd0);
        check("t1_first_an", an0, 4'b1110);
        run(3);
        check("t1_dead_an", an0, 4'b1111);

        // 2. no blanking, 0x3A5C
        cyc(1'b1, 32'h0000_3A5C);
        check("t2_pend_set", pend0, 1);
        run_to(0);
        check("t2_pend_before_wrap", pend0, 1);
        cyc(1'b0, 32'd0);
        check("t2_pend_clear", pend0, 0);
        check("t2_d0_seg", seg0, 7'b1000110);
        check("t2_d0_an",  an0, 4'b1110);
        run(SD);
        check("t2_d1_seg", seg0, 7'b0010010);
        check("t2_d1_an",  an0, 4'b1101);
        run(SD);
        check("t2_d2_seg", seg0, 7'b0001000);
        check("t2_d2_an",  an0, 4'b1011);
        run(SD);
        check("t2_d3_seg", seg0, 7'b0110000);
        check("t2_d3_an",  an0, 4'b0111);
        run(SD);
        check("t2_repeat_an", an0, 4'b1110);

        // 3. leading-zero blanking
        cyc(1'b1, 32'h0000_0050);
        run_to(1);
        check("t3_d0_seg", seg1, 7'b1000000);
        run(SD);
        check("t3_d1_seg", seg1, 7'b0010010);
        run(SD);
        check("t3_d2_seg", seg1, 7'b1111111);
        run(SD);
        check("t3_d3_seg", seg1, 7'b1111111);
        cyc(1'b1, 32'd0);
        run_to(1);
        check("t3_zero_d0", seg1, 7'b1000000);
        run(SD);
        check("t3_zero_d1", seg1, 7'b1111111);

        // 4. mid-frame loads, last wins at next frame
        cyc(1'b1, 32'h0000_1111);
        cyc(1'b0, 32'd0);
        cyc(1'b1, 32'h0000_2222);
        run_to(10);
        check("t4_old_kept", seg0, 7'b1000000);
        run_to(1);
        check("t4_new_d0", seg0, 7'b0100100);

        // 5. load in the wrap dead cycle beats the pending value
        run_to(6);
        cyc(1'b1, 32'h0000_1234);
        check("t5_pend", pend1, 1);
        run_to(0);
        cyc(1'b1, 32'h0000_BEEF);
        check("t5_d0_seg", seg1, 7'b0001110);
        check("t5_pend_clear", pend1, 0);
        run(3 * SD);
        check("t5_d3_seg", seg1, 7'b0000011);

        // 6. asynchronous reset during digit 2
        run_to(10);
        check("t6_dig_before", dig0, 2);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_async_seg", seg0, 7'b1111111);
        check("t6_async_an",  an0, 4'b1111);
        check("t6_async_dig", dig0, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        cyc(1'b0, 32'd0);
        check("t6_restart_seg", seg0, 7'b1000000);
        check("t6_restart_an",  an0, 4'b1110);

        // Randomized traffic, including occasional resets and wrap-cycle loads
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0:       v = $urandom;
                    1:       v = $urandom & 32'h0000_FFFF;
                    2:       v = $urandom & 32'h0000_00FF;
                    default: v = $urandom & 32'h0000_000F;
                endcase
                cyc($urandom_range(0, 5) == 0, v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
